// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: req/ack data bus, MEM/WB register, upstream stall
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  memop_i,
    input  logic [4:0]  waddr_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  waddr_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_o,
    output logic        align_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);
    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    typedef enum logic {S_IDLE, S_BUS} state_t;
    state_t r_state, w_state_nxt;

    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [4:0]  r_waddr_lat;
    logic [4:0]  r_waddr;
    logic        r_wreg;
    logic [31:0] r_wdata;
    logic        r_align_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    logic        w_is_lw, w_is_lb, w_is_lbu, w_is_sw, w_is_sb;
    logic        w_is_word, w_is_mem, w_misalign, w_start;
    logic [3:0]  w_be_byte;
    logic [31:0] w_rd_shift;
    logic [7:0]  w_rd_byte;

    assign w_is_lw    = (memop_i == OP_LW);
    assign w_is_lb    = (memop_i == OP_LB);
    assign w_is_lbu   = (memop_i == OP_LBU);
    assign w_is_sw    = (memop_i == OP_SW);
    assign w_is_sb    = (memop_i == OP_SB);
    assign w_is_word  = w_is_lw | w_is_sw;
    assign w_is_mem   = w_is_word | w_is_lb | w_is_lbu | w_is_sb;
    assign w_misalign = w_is_word && (wdata_i[1:0] != 2'b00);
    assign w_start    = (r_state == S_IDLE) && w_is_mem && !w_misalign;
    assign w_be_byte  = 4'b0001 << wdata_i[1:0];

    // Byte lane for LB/LBU comes from the offset latched at issue, not the live input.
    assign w_rd_shift = mem_rdata_i >> {r_off, 3'b000};
    assign w_rd_byte  = w_rd_shift[7:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start)   w_state_nxt = S_BUS;
            S_BUS:  if (mem_ack_i) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 3'b000;
            r_off       <= 2'b00;
            r_waddr_lat <= 5'd0;
            r_waddr     <= 5'd0;
            r_wreg      <= 1'b0;
            r_wdata     <= 32'd0;
            r_align_err <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_align_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op        <= memop_i;
                        r_off       <= wdata_i[1:0];
                        r_waddr_lat <= waddr_i;
                        r_wreg      <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_sw | w_is_sb;
                        r_mem_addr  <= {wdata_i[31:2], 2'b00};
                        r_mem_be    <= w_is_word ? 4'hF : w_be_byte;
                        r_mem_wdata <= w_is_sb ? {4{reg2_i[7:0]}} :
                                       w_is_sw ? reg2_i : 32'd0;
                    end else if (w_misalign) begin
                        r_waddr     <= waddr_i;
                        r_wreg      <= 1'b0;
                        r_wdata     <= wdata_i;
                        r_align_err <= 1'b1;
                    end else begin
                        r_waddr <= waddr_i;
                        r_wreg  <= wreg_i;
                        r_wdata <= wdata_i;
                    end
                end
                S_BUS: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_waddr   <= r_waddr_lat;
                        case (r_op)
                            OP_LW:  begin r_wreg <= 1'b1; r_wdata <= mem_rdata_i; end
                            OP_LB:  begin r_wreg <= 1'b1; r_wdata <= {{24{w_rd_byte[7]}}, w_rd_byte}; end
                            OP_LBU: begin r_wreg <= 1'b1; r_wdata <= {24'd0, w_rd_byte}; end
                            default: begin r_wreg <= 1'b0; r_wdata <= 32'd0; end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_o     = (r_state == S_BUS);
    assign waddr_o     = r_waddr;
    assign wreg_o      = r_wreg;
    assign wdata_o     = r_wdata;
    assign align_err_o = r_align_err;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_be_o    = r_mem_be;
    assign mem_wdata_o = r_mem_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage write-back and bus behaviour
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  memop_i;
    logic [4:0]  waddr_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] reg2_i;
    logic [4:0]  waddr_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_o;
    logic        align_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    localparam logic [2:0] NONE = 3'b000, LW = 3'b001, LB = 3'b010, LBU = 3'b011,
                           SW = 3'b100, SB = 3'b101;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        wreg;
        logic [31:0] wdata;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .memop_i(memop_i), .waddr_i(waddr_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .reg2_i(reg2_i), .waddr_o(waddr_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stall_o(stall_o), .align_err_o(align_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pop_cmp(input string tag);
        wb_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_wreg"}, 32'(wreg_o), 32'(e.wreg));
            if (e.wreg) check({tag, "_waddr"}, 32'(waddr_o), 32'(e.waddr));
            check({tag, "_wdata"}, wdata_o, e.wdata);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [4:0] wa, input logic we, input logic [31:0] d);
        memop_i = NONE; waddr_i = wa; wreg_i = we; wdata_i = d; reg2_i = $urandom;
        sb_q.push_back('{waddr: wa, wreg: we, wdata: d});
        step();
        check("alu_stall", 32'(stall_o), 32'd0);
        check("alu_req", 32'(mem_req_o), 32'd0);
        pop_cmp("alu");
    endtask

    task automatic mem_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [4:0] wa, input int nwait, input logic [31:0] rdata);
        logic        is_load;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] sh;
        logic [7:0]  b;
        wb_t         e;
        int          stall_cnt;
        is_load = (op == LW) || (op == LB) || (op == LBU);
        e_be = (op == LW || op == SW) ? 4'hF : 4'(4'b0001 << addr[1:0]);
        e_wd = (op == SB) ? {4{rt[7:0]}} : rt;
        sh = rdata >> {addr[1:0], 3'b000};
        b  = sh[7:0];
        e.waddr = wa;
        e.wreg  = is_load;
        e.wdata = (op == LW)  ? rdata :
                  (op == LB)  ? {{24{b[7]}}, b} :
                  (op == LBU) ? {24'd0, b} : 32'd0;
        sb_q.push_back(e);

        memop_i = op; wdata_i = addr; reg2_i = rt; waddr_i = wa; wreg_i = 1'b1;
        step();
        check("req_up", 32'(mem_req_o), 32'd1);
        check("bus_addr", mem_addr_o, {addr[31:2], 2'b00});
        check("bus_be", 32'(mem_be_o), 32'(e_be));
        check("bus_we", 32'(mem_we_o), 32'(!is_load));
        if (!is_load) check("bus_wdata", mem_wdata_o, e_wd);
        check("bubble_wreg", 32'(wreg_o), 32'd0);
        check("no_align_err", 32'(align_err_o), 32'd0);

        // upstream junk while stalled must be ignored
        memop_i = NONE; wreg_i = 1'b1; wdata_i = $urandom; waddr_i = 5'(wa + 1);
        stall_cnt = 0;
        for (int i = 0; i < nwait; i++) begin
            if (stall_o) stall_cnt++;
            mem_ack_i = 1'b0;
            step();
            check("hold_req", 32'(mem_req_o), 32'd1);
            check("hold_addr", mem_addr_o, {addr[31:2], 2'b00});
            check("hold_be", 32'(mem_be_o), 32'(e_be));
            check("wait_wreg", 32'(wreg_o), 32'd0);
        end
        if (stall_o) stall_cnt++;
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        check("stall_cycles", 32'(stall_cnt), 32'(nwait + 1));
        check("req_down", 32'(mem_req_o), 32'd0);
        check("stall_down", 32'(stall_o), 32'd0);
        pop_cmp("mem");
    endtask

    initial begin
        rst = 1'b1; memop_i = NONE; waddr_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0;
        reg2_i = 32'd0; mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
        step();
        step();
        check("rst_waddr", 32'(waddr_o), 32'd0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        rst = 1'b0;

        alu_op(5'd5, 1'b1, 32'h0000_1234);
        for (int i = 0; i < 6; i++) alu_op(5'($urandom), 1'($urandom), $urandom);

        // ack on a NONE cycle must not disturb anything
        mem_ack_i = 1'b1;
        alu_op(5'd9, 1'b1, 32'h0BAD_F00D);
        mem_ack_i = 1'b0;

        mem_op(LW,  32'h0000_0100, 32'd0,         5'd7,  2, 32'hDEAD_BEEF);
        mem_op(LB,  32'h0000_0103, 32'd0,         5'd8,  0, 32'h8011_2233);
        mem_op(LBU, 32'h0000_0103, 32'd0,         5'd9,  1, 32'h8011_2233);
        mem_op(LB,  32'h0000_0101, 32'd0,         5'd10, 0, 32'h8011_2233);
        mem_op(LBU, 32'h0000_0102, 32'd0,         5'd11, 0, 32'h8011_2233);
        mem_op(SB,  32'h0000_0201, 32'h0000_00A5, 5'd12, 0, 32'h1111_1111);
        mem_op(SW,  32'h0000_0300, 32'hCAFE_F00D, 5'd13, 3, 32'h2222_2222);
        alu_op(5'd3, 1'b1, 32'h0000_0042);
        mem_op(LW,  32'h0000_0104, 32'd0,         5'd14, 0, 32'h1357_9BDF);

        // misaligned SW/LW: no bus, one-cycle error pulse
        memop_i = SW; wdata_i = 32'h0000_0302; reg2_i = 32'h5555_5555; waddr_i = 5'd4; wreg_i = 1'b1;
        step();
        check("sw_mis_err", 32'(align_err_o), 32'd1);
        check("sw_mis_req", 32'(mem_req_o), 32'd0);
        check("sw_mis_wreg", 32'(wreg_o), 32'd0);
        check("sw_mis_stall", 32'(stall_o), 32'd0);
        memop_i = LW; wdata_i = 32'h0000_0101; waddr_i = 5'd6;
        step();
        check("lw_mis_err", 32'(align_err_o), 32'd1);
        check("lw_mis_req", 32'(mem_req_o), 32'd0);
        check("lw_mis_wreg", 32'(wreg_o), 32'd0);
        alu_op(5'd2, 1'b1, 32'h0000_0077);
        check("err_pulse_end", 32'(align_err_o), 32'd0);

        // reset during the second bus wait cycle aborts the load
        memop_i = LW; wdata_i = 32'h0000_0400; waddr_i = 5'd15; wreg_i = 1'b1;
        step();
        check("abort_req_up", 32'(mem_req_o), 32'd1);
        memop_i = NONE; wreg_i = 1'b0; wdata_i = 32'd0; waddr_i = 5'd0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_req", 32'(mem_req_o), 32'd0);
        check("abort_stall", 32'(stall_o), 32'd0);
        check("abort_wreg", 32'(wreg_o), 32'd0);
        check("abort_wdata", wdata_o, 32'd0);
        check("abort_addr", mem_addr_o, 32'd0);
        check("abort_be", 32'(mem_be_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        step();
        mem_ack_i = 1'b0;
        check("late_ack_wreg", 32'(wreg_o), 32'd0);
        check("late_ack_wdata", wdata_o, 32'd0);
        check("late_ack_stall", 32'(stall_o), 32'd0);
        alu_op(5'd1, 1'b1, 32'h0000_ABCD);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
